// File: rtl/dmem_access_unit.sv
// Load/store initiator between the memory stage and a word-addressed data memory.
// Sub-word stores are read-modify-write; loads are lane-selected and sign/zero-extended.
module dmem_access_unit #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    output logic              resp_err_o,
    output logic [31:0]       resp_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [31:0]       merge_q, merge_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              req_bad;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       load_ext;
    logic [3:0]        lane_en;
    logic [31:0]       lane_data;
    logic [31:0]       merged;

    assign req_bad = (req_size_i == 2'b11)
                   || ((req_size_i == 2'b01) && req_addr_i[0])
                   || ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00))
                   || (|req_addr_i[31:ADDR_W+2]);

    // Lane select and extension of the word read during LOAD.
    always_comb begin
        ld_byte = mem_rdata_i[7:0];
        case (addr_q[1:0])
            2'd1:    ld_byte = mem_rdata_i[15:8];
            2'd2:    ld_byte = mem_rdata_i[23:16];
            2'd3:    ld_byte = mem_rdata_i[31:24];
            default: ld_byte = mem_rdata_i[7:0];
        endcase
        ld_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
            2'b01:   load_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
            default: load_ext = mem_rdata_i;
        endcase
    end

    always_comb begin
        if (size_q == 2'b00) begin
            lane_en   = 4'b0001 << addr_q[1:0];
            lane_data = {4{wdata_q[7:0]}};
        end else begin
            lane_en   = addr_q[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{wdata_q[15:0]}};
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign merged[8*gi +: 8] = lane_en[gi] ? lane_data[8*gi +: 8] : mem_rdata_i[8*gi +: 8];
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        merge_d      = merge_q;
        rdata_d      = rdata_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_err_o   = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d  = req_addr_i[ADDR_W+1:0];
                    size_d  = req_size_i;
                    uns_d   = req_unsigned_i;
                    wdata_d = req_wdata_i;
                    err_d   = req_bad;
                    if (req_bad)
                        state_d = ST_RESP;
                    else if (!req_write_i)
                        state_d = ST_LOAD;
                    else if (req_size_i == 2'b10)
                        state_d = ST_STORE;
                    else
                        state_d = ST_RMW_RD;
                end
            end
            ST_LOAD: begin
                mem_read_o = 1'b1;
                mem_addr_o = addr_q[ADDR_W+1:2];
                rdata_d    = load_ext;
                state_d    = ST_RESP;
            end
            ST_STORE: begin
                mem_write_o = 1'b1;
                mem_addr_o  = addr_q[ADDR_W+1:2];
                mem_wdata_o = wdata_q;
                rdata_d     = '0;
                state_d     = ST_RESP;
            end
            ST_RMW_RD: begin
                mem_read_o = 1'b1;
                mem_addr_o = addr_q[ADDR_W+1:2];
                merge_d    = merged;
                state_d    = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                mem_write_o = 1'b1;
                mem_addr_o  = addr_q[ADDR_W+1:2];
                mem_wdata_o = merge_q;
                rdata_d     = '0;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                resp_valid_o = 1'b1;
                resp_err_o   = err_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign resp_rdata_o = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            merge_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed scenarios then random requests against a
// byte-array reference model of the data memory.
module tb_dmem_access_unit;

    localparam int ADDR_W = 7;
    localparam int WORDS  = 1 << ADDR_W;
    localparam int BYTES  = 4 * WORDS;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [31:0] tb_mem    [WORDS];
    logic [31:0] init_words[WORDS];
    logic        init_en;
    logic [7:0]  ref_b     [BYTES];
    logic [31:0] last_rd;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dmem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_write_i    (req_write),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .resp_valid_o   (resp_valid),
        .resp_err_o     (resp_err),
        .resp_rdata_o   (resp_rdata),
        .mem_addr_o     (mem_addr),
        .mem_read_o     (mem_read),
        .mem_write_o    (mem_write),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata)
    );

    assign mem_rdata = mem_read ? tb_mem[mem_addr] : 32'h0;

    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < WORDS; i++) tb_mem[i] <= init_words[i];
        end else if (mem_write) begin
            tb_mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
    endfunction

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic un,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input bit hold, output logic [31:0] rd);
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [31:0] val;
        logic [31:0] mask;
        int          exp_lat, exp_nrd, exp_nwr, nbytes;
        int          lat, nrd, nwr;
        bit          done;
        logic        got_err;
        logic [31:0] got_rd;

        nbytes  = 1 << sz;
        exp_err = (sz == 2'b11) || (sz == 2'b01 && addr[0]) ||
                  (sz == 2'b10 && addr[1:0] != 2'b00) || (addr >= BYTES);
        if (exp_err) begin
            exp_lat = 1; exp_nrd = 0; exp_nwr = 0; exp_rd = last_rd;
        end else if (!wr) begin
            exp_lat = 2; exp_nrd = 1; exp_nwr = 0;
            val = 32'h0;
            for (int k = 0; k < nbytes; k++) val |= 32'(ref_b[addr + k]) << (8 * k);
            if (!un && nbytes < 4) begin
                mask = (32'd1 << (8 * nbytes)) - 32'd1;
                if (val[8 * nbytes - 1]) val |= ~mask;
            end
            exp_rd = val;
        end else begin
            exp_lat = (nbytes == 4) ? 2 : 3;
            exp_nrd = (nbytes == 4) ? 0 : 1;
            exp_nwr = 1;
            exp_rd  = 32'h0;
            for (int k = 0; k < nbytes; k++) ref_b[addr + k] = 8'(wd >> (8 * k));
        end

        @(negedge clk);
        chk("ready_idle", {31'b0, req_ready}, 32'd1);
        chk("resp_idle", {31'b0, resp_valid}, 32'd0);
        req_write = wr; req_size = sz; req_unsigned = un; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        req_write = $urandom; req_size = 2'($urandom); req_unsigned = $urandom;
        req_addr = $urandom; req_wdata = $urandom;

        lat = 0; nrd = 0; nwr = 0; done = 0; got_err = 1'bx; got_rd = 'x;
        for (int n = 1; n <= 6 && !done; n++) begin
            @(negedge clk);
            chk("ready_busy", {31'b0, req_ready}, 32'd0);
            chk("rd_wr_excl", {31'b0, mem_read & mem_write}, 32'd0);
            if (mem_read)  begin nrd++; chk("rd_addr", 32'(mem_addr), addr >> 2); end
            if (mem_write) begin nwr++; chk("wr_addr", 32'(mem_addr), addr >> 2); end
            if (resp_valid) begin
                done = 1; lat = n; got_err = resp_err; got_rd = resp_rdata;
                req_valid = 1'b0;
            end
        end
        chk("resp_seen", {31'b0, done}, 32'd1);
        chk("latency", lat, exp_lat);
        chk("resp_err", {31'b0, got_err}, {31'b0, exp_err});
        chk("resp_rdata", got_rd, exp_rd);
        chk("n_reads", nrd, exp_nrd);
        chk("n_writes", nwr, exp_nwr);
        if (wr && !exp_err) chk("mem_word", tb_mem[addr >> 2], ref_word(int'(addr >> 2)));
        last_rd = exp_rd;
        $display("req wr=%0d sz=%0d un=%0d addr=%h wd=%h -> err=%0d rd=%h lat=%0d",
                 wr, sz, un, addr, wd, got_err, got_rd, lat);
        rd = got_rd;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] w;
        logic [1:0]  sz;
        logic [31:0] a;
        int          r;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; last_rd = 32'h0;
        for (int i = 0; i < WORDS; i++) begin
            w = $urandom;
            init_words[i] = w;
            for (int k = 0; k < 4; k++) ref_b[4*i + k] = 8'(w >> (8 * k));
        end
        init_en = 1'b1;
        @(posedge clk);
        #1 init_en = 1'b0;
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        do_req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, rd);
        chk("sw_word4", tb_mem[4], 32'hDEADBEEF);
        do_req(0, 2'b10, 0, 32'h10, 32'h0, 0, rd);
        chk("lw_deadbeef", rd, 32'hDEADBEEF);

        do_req(1, 2'b10, 0, 32'h10, 32'h11223344, 0, rd);
        do_req(1, 2'b00, 0, 32'h12, 32'h123456A5, 0, rd);
        chk("sb_merge", tb_mem[4], 32'h11A53344);

        do_req(1, 2'b10, 0, 32'h10, 32'h80FF7F01, 0, rd);
        do_req(0, 2'b00, 0, 32'h10, 32'h0, 0, rd); chk("lb_10", rd, 32'h00000001);
        do_req(0, 2'b00, 0, 32'h12, 32'h0, 0, rd); chk("lb_12", rd, 32'hFFFFFFFF);
        do_req(0, 2'b00, 1, 32'h12, 32'h0, 0, rd); chk("lbu_12", rd, 32'h000000FF);
        do_req(0, 2'b01, 0, 32'h12, 32'h0, 0, rd); chk("lh_12", rd, 32'hFFFF80FF);
        do_req(0, 2'b01, 1, 32'h12, 32'h0, 0, rd); chk("lhu_12", rd, 32'h000080FF);

        do_req(0, 2'b10, 0, 32'h11, 32'h0, 0, rd);
        chk("err_keeps_rdata", rd, 32'h000080FF);
        do_req(1, 2'b01, 0, 32'h13, 32'hCAFE, 0, rd);
        do_req(0, 2'b11, 0, 32'h14, 32'h0, 0, rd);
        do_req(0, 2'b10, 0, 32'h200, 32'h0, 0, rd);

        // Reset while the read half of a byte store is in flight.
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h5A; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("rmw_rd_active", {31'b0, mem_read}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", {31'b0, req_ready}, 32'd1);
        chk("arst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
        chk("arst_resp", {30'b0, resp_valid, resp_err}, 32'd0);
        chk("arst_rdata", resp_rdata, 32'd0);
        chk("arst_mem_addr", 32'(mem_addr), 32'd0);
        chk("arst_mem_wdata", mem_wdata, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("arst_word8", tb_mem[8], ref_word(8));
        rst_n = 1'b1;
        last_rd = 32'h0;
        @(negedge clk);
        chk("arst_release_ready", {31'b0, req_ready}, 32'd1);
        $display("async reset during RMW_RD done");

        do_req(0, 2'b10, 0, 32'h10, 32'h0, 1, rd);
        chk("hold_lw", rd, 32'h80FF7F01);
        do_req(1, 2'b01, 0, 32'h22, 32'hBEEF1234, 1, rd);
        chk("hold_sh", tb_mem[8], ref_word(8));

        for (int t = 0; t < 60; t++) begin
            sz = 2'($urandom);
            r  = int'($urandom_range(0, 15));
            if (r == 0) a = $urandom;
            else begin
                a = 32'($urandom_range(0, BYTES - 1));
                if (r < 12 && sz != 2'b11) a &= ~((32'd1 << sz) - 32'd1);
            end
            do_req($urandom, sz, $urandom, a, $urandom, ($urandom_range(0, 3) == 0), rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
